psram_responder: RTL and testbench

PSRAM_RESPONDER -- requirements
Module: psram_responder

---
 rtl/psram_responder.sv | 155 +++++++++++++++
 tb/tb_psram_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/psram_responder.sv
// rtl/psram_responder.sv - QPI PSRAM responder model with SPI 0x35 mode entry and internal word memory.
// Optional burst continuation is enabled by defining PSRAM_RSP_BURST_EN.
module psram_responder #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       i_clk,
  input  logic       arst,
  input  logic       i_psram_csn,
  input  logic [7:0] i_psram_data,
  output logic [7:0] o_psram_data,
  output logic [7:0] o_psram_oe,
  output logic       o_qpi_mode,
  output logic       o_cmd_err
);

  typedef enum logic [3:0] {
    IDLE, CMD_HI, CMD_LO, ADDR, WAIT, RD_HI, RD_LO, WR_HI, WR_LO, DRAIN
  } state_t;

  state_t            state, state_n, cur;
  logic [15:0]       mem [2**MEM_AW];
  logic [3:0]        cmd_hi;
  logic              is_rd;
  logic [MEM_AW-1:0] idx, idx_n, fetch_idx;
  logic [7:0]        cnt, cnt_n;
  logic [7:0]        wr_hi;
  logic [15:0]       rd_word;
  logic [7:0]        spi_sreg;
  logic [3:0]        spi_cnt;
  logic              beat, fetch, mem_we, set_err;

  assign beat = !i_psram_csn;

  always_comb begin
    // The first beat of a transaction is taken while the register still says IDLE.
    cur          = (state == IDLE && beat) ? CMD_HI : state;
    state_n      = cur;
    cnt_n        = cnt;
    idx_n        = idx;
    fetch        = 1'b0;
    fetch_idx    = idx;
    mem_we       = 1'b0;
    set_err      = 1'b0;
    o_psram_oe   = 8'h00;
    o_psram_data = 8'h00;
    if (beat && cur == RD_HI) begin
      o_psram_oe   = 8'hFF;
      o_psram_data = rd_word[15:8];
    end else if (beat && cur == RD_LO) begin
      o_psram_oe   = 8'hFF;
      o_psram_data = rd_word[7:0];
    end
    if (!o_qpi_mode || !beat) begin
      state_n = IDLE;
    end else begin
      case (cur)
        CMD_HI: state_n = CMD_LO;
        CMD_LO: begin
          cnt_n = 8'd0;
          if ({cmd_hi, i_psram_data[3:0]} == 8'h38 || {cmd_hi, i_psram_data[3:0]} == 8'hEB) begin
            state_n = ADDR;
          end else begin
            set_err = 1'b1;
            state_n = DRAIN;
          end
        end
        ADDR: begin
          // Only the low MEM_AW address bits survive the shift, giving the aliasing for free.
          idx_n = MEM_AW'({idx, i_psram_data[3:0]});
          cnt_n = cnt + 8'd1;
          if (cnt == 8'd5) begin
            cnt_n = 8'd0;
            if (is_rd) begin
              fetch     = 1'b1;
              fetch_idx = idx_n;
              state_n   = (WAIT_CYCLES == 0) ? RD_HI : WAIT;
            end else begin
              state_n = WR_HI;
            end
          end
        end
        WAIT: begin
          cnt_n = cnt + 8'd1;
          if (cnt == 8'(WAIT_CYCLES - 1)) state_n = RD_HI;
        end
        RD_HI: state_n = RD_LO;
        RD_LO: begin
`ifdef PSRAM_RSP_BURST_EN
          idx_n     = idx + MEM_AW'(1);
          fetch     = 1'b1;
          fetch_idx = idx_n;
          state_n   = RD_HI;
`else
          state_n = DRAIN;
`endif
        end
        WR_HI: state_n = WR_LO;
        WR_LO: begin
          mem_we = 1'b1;
`ifdef PSRAM_RSP_BURST_EN
          idx_n   = idx + MEM_AW'(1);
          state_n = WR_HI;
`else
          state_n = DRAIN;
`endif
        end
        default: state_n = DRAIN;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      idx        <= '0;
      cmd_hi     <= 4'd0;
      is_rd      <= 1'b0;
      wr_hi      <= 8'd0;
      rd_word    <= 16'd0;
      spi_sreg   <= 8'd0;
      spi_cnt    <= 4'd0;
      o_qpi_mode <= 1'b0;
      o_cmd_err  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      if (set_err) o_cmd_err <= 1'b1;
      if (fetch) rd_word <= mem[fetch_idx];
      if (beat && o_qpi_mode) begin
        if (cur == CMD_HI) cmd_hi <= i_psram_data[3:0];
        if (cur == CMD_LO) is_rd <= ({cmd_hi, i_psram_data[3:0]} == 8'hEB);
        if (cur == WR_HI) wr_hi <= i_psram_data;
      end
      // SPI entry needs exactly eight beats; the counter saturates past that.
      if (!o_qpi_mode) begin
        if (beat) begin
          spi_sreg <= {spi_sreg[6:0], i_psram_data[0]};
          if (spi_cnt != 4'd9) spi_cnt <= spi_cnt + 4'd1;
        end else begin
          if (spi_cnt == 4'd8 && spi_sreg == 8'h35) o_qpi_mode <= 1'b1;
          spi_cnt  <= 4'd0;
          spi_sreg <= 8'd0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[idx] <= {wr_hi, i_psram_data};
  end

endmodule

// File: tb/tb_psram_responder.sv
// tb/tb_psram_responder.sv - randomized self-checking bench for psram_responder against a transaction-level model.
module tb_psram_responder;
  localparam int AW = 8;
  localparam int WC = 6;
`ifdef PSRAM_RSP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst, csn;
  logic [7:0] din, dout, oe;
  logic       qpi, err;

  psram_responder #(.MEM_AW(AW), .WAIT_CYCLES(WC)) dut (
    .i_clk(clk), .arst(arst), .i_psram_csn(csn), .i_psram_data(din),
    .o_psram_data(dout), .o_psram_oe(oe), .o_qpi_mode(qpi), .o_cmd_err(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ref_mem [2**AW];
  bit          ref_ok  [2**AW];
  bit          ref_qpi = 1'b0;
  bit          ref_err = 1'b0;
  logic [15:0] wbuf [4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, output logic [7:0] o_d, output logic [7:0] o_oe);
    @(negedge clk);
    csn = 1'b0;
    din = d;
    #1;
    o_d  = dout;
    o_oe = oe;
    @(posedge clk);
  endtask

  task automatic end_txn;
    @(negedge clk);
    csn = 1'b1;
    din = 8'($urandom);
    #1;
    check_eq("oe_at_csn_rise", oe, 8'h00);
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic q_nib(input logic [3:0] n);
    logic [7:0] od, oo;
    drive({4'($urandom), n}, od, oo);
    check_eq("oe_hdr", oo, 8'h00);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    q_nib(cmd[7:4]);
    q_nib(cmd[3:0]);
    for (int i = 5; i >= 0; i--) q_nib(a[4*i +: 4]);
  endtask

  task automatic spi_send(input logic [7:0] b);
    logic [7:0] r, od, oo;
    for (int i = 7; i >= 0; i--) begin
      r    = 8'($urandom);
      r[0] = b[i];
      drive(r, od, oo);
    end
    end_txn;
    if (b == 8'h35) ref_qpi = 1'b1;
    check_eq("qpi_mode", qpi, ref_qpi);
  endtask

  task automatic qwrite(input logic [23:0] a, input int n, input bit partial);
    logic [7:0] od, oo;
    int         w;
    send_hdr(8'h38, a);
    for (int k = 0; k < n; k++) begin
      drive(wbuf[k][15:8], od, oo);
      check_eq("oe_wr", oo, 8'h00);
      if (!(partial && k == n - 1)) drive(wbuf[k][7:0], od, oo);
    end
    end_txn;
    if (ref_qpi) begin
      for (int k = 0; k < n; k++) begin
        if ((k == 0 || BURST) && !(partial && k == n - 1)) begin
          w          = (int'(a) + k) % (1 << AW);
          ref_mem[w] = wbuf[k];
          ref_ok[w]  = 1'b1;
        end
      end
    end
  endtask

  task automatic qread(input logic [23:0] a, input int n);
    logic [7:0] od, oo;
    int         w;
    bit         live;
    send_hdr(8'hEB, a);
    for (int i = 0; i < WC; i++) begin
      drive(8'($urandom), od, oo);
      check_eq("oe_wait", oo, 8'h00);
    end
    for (int k = 0; k < n; k++) begin
      w    = (int'(a) + k) % (1 << AW);
      live = ref_qpi && (k == 0 || BURST);
      for (int h = 1; h >= 0; h--) begin
        drive(8'($urandom), od, oo);
        check_eq("rd_oe", oo, live ? 8'hFF : 8'h00);
        if (!live) check_eq("rd_idle_data", od, 8'h00);
        else if (ref_ok[w]) check_eq("rd_data", od, h ? ref_mem[w][15:8] : ref_mem[w][7:0]);
      end
    end
    end_txn;
  endtask

  task automatic qbad(input logic [7:0] cmd);
    logic [7:0] od, oo;
    q_nib(cmd[7:4]);
    q_nib(cmd[3:0]);
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), od, oo);
      check_eq("oe_bad_cmd", oo, 8'h00);
    end
    end_txn;
    if (ref_qpi && cmd != 8'h38 && cmd != 8'hEB) ref_err = 1'b1;
    check_eq("cmd_err", err, ref_err);
  endtask

  initial begin
    logic [23:0] a, a2;
    arst = 1'b1;
    csn  = 1'b1;
    din  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_qpi", qpi, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_oe", oe, 8'h00);
    check_eq("rst_data", dout, 8'h00);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);

    spi_send(8'h34);
    spi_send(8'h35);

    wbuf[0] = 16'hBEEF;
    qwrite(24'h000012, 1, 1'b0);
    qread(24'h000012, 1);

    wbuf[0] = 16'hA5A5;
    qwrite(24'h000012, 1, 1'b1);
    qread(24'h000012, 1);

    wbuf[0] = 16'h1111; qwrite(24'h000000, 1, 1'b0);
    wbuf[0] = 16'h2222; qwrite(24'h000001, 1, 1'b0);
    wbuf[0] = 16'hC0DE; wbuf[1] = 16'hD00D; wbuf[2] = 16'hF00D;
    qwrite(24'h0000FF, 3, 1'b0);
    qread(24'h0000FF, 1);
    qread(24'h000000, 1);
    qread(24'h000001, 1);
    qread(24'h0000FF, 3);

    for (int it = 0; it < 10; it++) begin
      a = 24'($urandom);
      for (int k = 0; k < 3; k++) wbuf[k] = 16'($urandom);
      qwrite(a, $urandom_range(1, 3), 1'b0);
      a2 = ($urandom_range(0, 1) == 1) ? a : (a ^ 24'(($urandom_range(1, 255)) << AW));
      qread(a2, $urandom_range(1, 3));
    end

    qbad(8'h9F);
    qread(24'h000012, 1);
    check_eq("cmd_err_sticky", err, ref_err);

    q_nib(4'hE); q_nib(4'hB); q_nib(4'h0); q_nib(4'h0); q_nib(4'h1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    ref_qpi = 1'b0;
    ref_err = 1'b0;
    check_eq("arst_qpi", qpi, 1'b0);
    check_eq("arst_err", err, 1'b0);
    check_eq("arst_oe", oe, 8'h00);
    check_eq("arst_data", dout, 8'h00);
    @(negedge clk);
    arst = 1'b0;
    csn  = 1'b1;
    @(posedge clk);
    qread(24'h000012, 1);
    check_eq("no_reentry_qpi", qpi, ref_qpi);
    check_eq("no_reentry_err", err, ref_err);

    spi_send(8'h35);
    qread(24'h000012, 1);
    qread(24'h0000FF, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
